// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the RV32I hazard/forwarding controller
package hazard_pkg;

  // Descriptor rd width; the controller's RA_W must equal this.
  localparam int DESC_RA_W = 5;
  localparam logic [DESC_RA_W-1:0] NO_REG = '0;

  typedef struct packed {
    logic [DESC_RA_W-1:0] rd;
    logic                 we;
    logic                 ld;
  } desc_t;

  localparam desc_t DESC_NONE = '{rd: NO_REG, we: 1'b0, ld: 1'b0};

  typedef enum logic [1:0] {
    RUN,
    LSTALL,
    FLUSH
  } state_t;

  typedef struct packed {
    logic ee;
    logic ese;
    logic me;
  } fwd_sel_t;

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - one source operand against the EX and MEM producer descriptors
module fwd_match
  import hazard_pkg::*;
(
  input  logic [DESC_RA_W-1:0] src_i,
  input  logic                 use_i,
  input  desc_t                ex_i,
  input  desc_t                mem_i,
  output fwd_sel_t             sel_o
);

  logic hit_ex;
  logic hit_mem;

  assign hit_ex  = use_i && (src_i != NO_REG) && ex_i.we  && (ex_i.rd  == src_i);
  assign hit_mem = use_i && (src_i != NO_REG) && mem_i.we && (mem_i.rd == src_i);

  // A load hitting in EX still shadows older producers; the stall resolves it later via me.
  assign sel_o.ee  = hit_ex && !ex_i.ld;
  assign sel_o.ese = !hit_ex && hit_mem && !mem_i.ld;
  assign sel_o.me  = !hit_ex && hit_mem && mem_i.ld;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - forward selects, load-use stall and redirect flush; HAZARD_PERF_CNT_EN adds perf counters
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W         = 5,
  parameter int FLUSH_CYCLES = 2
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W        = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_we,
  input  logic            id_ld,
  input  logic            ex_redirect,
  input  logic            mem_stall,
  output logic            ee_fwd1,
  output logic            ee_fwd2,
  output logic            ese_fwd1,
  output logic            ese_fwd2,
  output logic            me_fwd1,
  output logic            me_fwd2,
  output logic            stall_if,
  output logic            bubble_ex,
  output logic            flush_id,
  output logic            busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  desc_t    ex_q, m_q, id_desc;
  state_t   state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  fwd_sel_t fwd1_q, fwd2_q, sel1, sel2;
  logic     load_use;

  assign id_desc = '{rd: id_rd, we: id_we, ld: id_ld};

  fwd_match u_match1 (
    .src_i (id_rs1),
    .use_i (id_use_rs1),
    .ex_i  (ex_q),
    .mem_i (m_q),
    .sel_o (sel1)
  );

  fwd_match u_match2 (
    .src_i (id_rs2),
    .use_i (id_use_rs2),
    .ex_i  (ex_q),
    .mem_i (m_q),
    .sel_o (sel2)
  );

  assign load_use = ex_q.ld && ex_q.we && (ex_q.rd != NO_REG) &&
                    ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_q.rd)));

  // The detecting RUN cycle supplies the first bubble itself, so FLUSH only covers the rest.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_if  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (mem_stall) begin
      stall_if = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_redirect) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
            cnt_d     = 2'(FLUSH_CYCLES - 1);
            state_d   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else if (load_use) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
            state_d   = LSTALL;
          end
        end
        LSTALL: state_d = RUN;
        FLUSH: begin
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
          cnt_d     = cnt_q - 2'd1;
          if (cnt_d == 2'd0) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q    <= DESC_NONE;
      m_q     <= DESC_NONE;
      state_q <= RUN;
      cnt_q   <= 2'd0;
      fwd1_q  <= '0;
      fwd2_q  <= '0;
    end else if (!mem_stall) begin
      m_q     <= ex_q;
      ex_q    <= bubble_ex ? DESC_NONE : id_desc;
      fwd1_q  <= bubble_ex ? '0 : sel1;
      fwd2_q  <= bubble_ex ? '0 : sel2;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ee_fwd1  = fwd1_q.ee;
  assign ese_fwd1 = fwd1_q.ese;
  assign me_fwd1  = fwd1_q.me;
  assign ee_fwd2  = fwd2_q.ee;
  assign ese_fwd2 = fwd2_q.ese;
  assign me_fwd2  = fwd2_q.me;
  assign busy     = (state_q != RUN);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((state_q == LSTALL) && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (!mem_stall && (state_q == RUN) && ex_redirect && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
